uart_cmd_sequencer: RTL and testbench
=====================================

// Module: uart_cmd_sequencer
// PURPOSE
//  Sits behind the UART byte receiver and sequences its output into 4-byte command frames.
//  Frame format: SYNC, ADDR, DATA, CSUM.
//  Valid frames become one register write on a valid/ready write port.
//  Malformed, stalled and overrun traffic is flagged and discarded, so one rx path can configure the design.
// PARAMETERS
//  SYNC_BYTE    8'hAA    frame start marker
//  ADDR_W       4        write address width; ADDR byte bits [7:ADDR_W] must be 0
//  TIMEOUT_CYC  500000   max clk cycles between bytes inside a frame (10 ms at 50 MHz)
//  SAMPLE_DLY   2        clk cycles from rx_int falling edge to rx_data valid
// PORTS
//  clk          in   1       system clock, 50 MHz
//  rst          in   1       async reset, active-high
//  rx_int       in   1       receiver busy flag; high while a byte is being received
//  rx_data      in   8       last received byte from the receiver
//  wr_ready     in   1       register sink accepts the write when high
//  wr_en        out  1       write request, held until accepted
//  wr_addr      out  ADDR_W  write address
//  wr_data      out  8       write data
//  frame_err    out  1       1-cycle pulse: bad ADDR range or checksum
//  timeout_err  out  1       1-cycle pulse: inter-byte gap exceeded inside a frame
//  overrun_err  out  1       1-cycle pulse: byte arrived while a write was pending
//  busy         out  1       high whenever the FSM is not in IDLE
//  frame_cnt    out  8       count of accepted writes
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; byte-delay pipe, timeout counter and frame_cnt cleared.
//   Reset applies immediately mid-frame or mid-write: wr_en drops and the partial frame is lost.
//  Byte event:
//   - rx_int registered once; falling edge = rx_int_q & ~rx_int.
//   - Byte is taken from rx_data exactly SAMPLE_DLY cycles after the edge (byte_vld, 1-cycle pulse).
//   - A new falling edge during the delay restarts the delay; the earlier byte is lost.
//  FSM:
//   - IDLE:  byte_vld & byte==SYNC_BYTE -> ADDR. Any other byte is ignored silently.
//   - ADDR:  byte_vld -> store a, go to DATA.
//   - DATA:  byte_vld -> store d, go to CSUM.
//   - CSUM:  byte_vld, check byte == (a ^ d) and a[7:ADDR_W]==0.
//            Pass -> WRITE. Fail -> frame_err pulse next cycle, then IDLE.
//   - WRITE: wr_en=1, wr_addr=a[ADDR_W-1:0], wr_data=d, all held stable.
//            Transfer on a clk edge with wr_en & wr_ready.
//            wr_en is 0 the following cycle; frame_cnt+1 (wraps 255->0); FSM -> IDLE.
//            A byte_vld while in WRITE -> overrun_err pulse; the byte is discarded (not parsed as SYNC).
//  Timing:
//   - Minimum latency from CSUM byte_vld to wr_en high is 1 cycle.
//   - If wr_ready is already high, the write completes 1 cycle later.
//  Timeout:
//   - Counter cleared on entering ADDR and on every byte_vld.
//   - Increments each cycle in ADDR/DATA/CSUM.
//   - Reaching TIMEOUT_CYC-1 -> timeout_err pulse, FSM -> IDLE.
//   - Not active in IDLE or WRITE; WRITE waits forever on wr_ready.
//   - byte_vld and timeout in the same cycle: the byte wins and the counter clears.
//  Errors: frame_err, timeout_err and overrun_err are mutually exclusive per cycle, each a single-cycle pulse.
//  Widths: counter is $clog2(TIMEOUT_CYC) bits; checksum is 8-bit XOR, with no carry.
// TESTING
//  1. Send AA 03 5C 5F with wr_ready=1.
//     -> one wr_en pulse, addr=3, data=5C; frame_cnt 0->1; no error pulses.
//  2. Send AA 03 5C 00 (bad CSUM).
//     -> frame_err single pulse; wr_en stays 0; busy low after.
//     Send AA 13 00 13 (ADDR out of range) -> frame_err.
//  3. Send AA 02, then idle for TIMEOUT_CYC cycles.
//     -> timeout_err pulse at cycle TIMEOUT_CYC after the 02 byte, FSM IDLE.
//     Then send a full valid frame -> accepted.
//  4. Send a valid frame with wr_ready=0 for 100 cycles; send byte AA in the meantime.
//     -> wr_en/addr/data stable throughout, overrun_err pulse; raise wr_ready -> single transfer.
//  5. Send 55 11 AA 01 02 03 (noise before SYNC).
//     -> noise ignored, write addr=1, data=02.
//     Run 256 valid frames -> frame_cnt wraps to 0.
//  6. Assert rst during the DATA byte and during WRITE.
//     -> all outputs 0 at once; next valid frame accepted normally.

Source files
------------

// File: rtl/uart_cmd_sequencer.sv
// UART command sequencer: assembles SYNC/ADDR/DATA/CSUM byte frames from the receiver
// into single register writes on a valid/ready port, flagging bad, stalled and overrun traffic.
module uart_cmd_sequencer #(
  parameter logic [7:0] SYNC_BYTE   = 8'hAA,
  parameter int         ADDR_W      = 4,
  parameter int         TIMEOUT_CYC = 500000,
  parameter int         SAMPLE_DLY  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_int,
  input  logic [7:0]        rx_data,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_err,
  output logic              timeout_err,
  output logic              overrun_err,
  output logic              busy,
  output logic [7:0]        frame_cnt
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_CSUM,
    S_WRITE
  } state_t;

  state_t                state_q, state_d;
  logic                  rx_int_q;
  logic [SAMPLE_DLY-1:0] dly_q, dly_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [7:0]            addr_q, addr_d;
  logic [7:0]            data_q, data_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  ferr_q, ferr_d;

  logic rx_fall;
  logic byte_vld;
  logic in_frame;
  logic tmo_hit;
  logic csum_pass;
  logic wr_xfer;

  function automatic logic frame_ok(input logic [7:0] a, input logic [7:0] d,
                                    input logic [7:0] c);
    logic [7:0] hi;
    hi = a >> ADDR_W;
    return (c == (a ^ d)) && (hi == 8'd0);
  endfunction

  // Byte event: a one-hot delay line started by each rx_int falling edge; a newer
  // edge reloads it so only the most recent byte is ever sampled.
  assign rx_fall  = rx_int_q & ~rx_int;
  assign byte_vld = dly_q[SAMPLE_DLY-1];

  always_comb begin
    if (rx_fall) begin
      dly_d = SAMPLE_DLY'(1);
    end else begin
      dly_d = dly_q << 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_int_q <= 1'b0;
      dly_q    <= '0;
    end else begin
      rx_int_q <= rx_int;
      dly_q    <= dly_d;
    end
  end

  assign in_frame  = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign tmo_hit   = in_frame && !byte_vld && (tmo_q == TMO_LAST);
  assign csum_pass = frame_ok(addr_q, data_q, rx_data);
  assign wr_xfer   = (state_q == S_WRITE) && wr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (byte_vld && (rx_data == SYNC_BYTE)) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (byte_vld)     state_d = S_DATA;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_DATA: begin
        if (byte_vld)     state_d = S_CSUM;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_CSUM: begin
        if (byte_vld)     state_d = csum_pass ? S_WRITE : S_IDLE;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_WRITE: begin
        if (wr_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Overrun is raised straight from WRITE; the byte never reaches the IDLE sync check.
  always_comb begin
    wr_en       = (state_q == S_WRITE);
    busy        = (state_q != S_IDLE);
    wr_addr     = addr_q[ADDR_W-1:0];
    wr_data     = data_q;
    frame_err   = ferr_q;
    timeout_err = tmo_hit;
    overrun_err = (state_q == S_WRITE) && byte_vld;
    frame_cnt   = cnt_q;
  end

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    if ((state_q == S_ADDR) && byte_vld) addr_d = rx_data;
    if ((state_q == S_DATA) && byte_vld) data_d = rx_data;
    ferr_d = (state_q == S_CSUM) && byte_vld && !csum_pass;
    cnt_d  = wr_xfer ? cnt_q + 8'd1 : cnt_q;
    if (in_frame && !byte_vld && !tmo_hit) begin
      tmo_d = tmo_q + 1'b1;
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
      ferr_q <= 1'b0;
      cnt_q  <= '0;
      tmo_q  <= '0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      ferr_q <= ferr_d;
      cnt_q  <= cnt_d;
      tmo_q  <= tmo_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Bench for uart_cmd_sequencer: directed scenarios plus randomized byte streams checked
// against a frame-buffer model of the command protocol.
module tb_uart_cmd_sequencer;

  localparam int         TMO  = 64;
  localparam int         DLY  = 2;
  localparam logic [7:0] SYNC = 8'hAA;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_int = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       wr_ready = 1'b0;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err, timeout_err, overrun_err, busy;
  logic [7:0] frame_cnt;

  uart_cmd_sequencer #(
    .SYNC_BYTE  (SYNC),
    .ADDR_W     (4),
    .TIMEOUT_CYC(TMO),
    .SAMPLE_DLY (DLY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_int     (rx_int),
    .rx_data    (rx_data),
    .wr_ready   (wr_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_err  (frame_err),
    .timeout_err(timeout_err),
    .overrun_err(overrun_err),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  int          cyc = 0, last_fall = 0, first_wr = 0, tmo_at = 0;
  int          n_ferr = 0, n_tmo = 0, n_ovr = 0, n_wr_cyc = 0;
  int          excl_viol = 0, hold_viol = 0;
  logic        rx_prev = 1'b0, wr_en_prev = 1'b0, pend_q = 1'b0, acc_q = 1'b0;
  logic [11:0] pend_val = '0;
  logic [11:0] wq[$];

  always @(negedge clk) begin
    cyc     <= cyc + 1;
    rx_prev <= rx_int;
    if (rx_prev && !rx_int) last_fall <= cyc;
    if (rst) begin
      pend_q     <= 1'b0;
      acc_q      <= 1'b0;
      wr_en_prev <= 1'b0;
    end else begin
      if (frame_err)   n_ferr <= n_ferr + 1;
      if (timeout_err) n_tmo  <= n_tmo + 1;
      if (overrun_err) n_ovr  <= n_ovr + 1;
      if ((int'(frame_err) + int'(timeout_err) + int'(overrun_err)) > 1) excl_viol <= excl_viol + 1;
      if (timeout_err) tmo_at <= cyc;
      if (wr_en && !wr_en_prev) first_wr <= cyc;
      if (wr_en) n_wr_cyc <= n_wr_cyc + 1;
      if ((pend_q && (!wr_en || ({wr_addr, wr_data} != pend_val))) || (acc_q && wr_en))
        hold_viol <= hold_viol + 1;
      pend_q     <= wr_en && !wr_ready;
      pend_val   <= {wr_addr, wr_data};
      acc_q      <= wr_en && wr_ready;
      wr_en_prev <= wr_en;
      if (wr_en && wr_ready) wq.push_back({wr_addr, wr_data});
    end
  end

  // Reference model: a frame buffer that collects bytes after SYNC and judges each 4-byte frame.
  logic [7:0]  fbuf[$];
  logic [11:0] ewq[$];
  int          exp_ferr = 0, exp_tmo = 0, exp_ovr = 0;
  logic [7:0]  exp_cnt = 8'd0;

  task automatic mdl_byte(input logic [7:0] b);
    if (fbuf.size() == 0) begin
      if (b == SYNC) fbuf.push_back(b);
    end else begin
      fbuf.push_back(b);
      if (fbuf.size() == 4) begin
        if ((fbuf[3] == (fbuf[1] ^ fbuf[2])) && (fbuf[1] < 8'd16)) begin
          ewq.push_back({fbuf[1][3:0], fbuf[2]});
          exp_cnt = exp_cnt + 8'd1;
        end else begin
          exp_ferr++;
        end
        fbuf.delete();
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_raw(input logic [7:0] b);
    int hold, gap;
    hold = $urandom_range(2, 5);
    gap  = $urandom_range(2, 8);
    rx_int = 1'b1;
    repeat (hold) tick();
    rx_int  = 1'b0;
    rx_data = b;
    repeat (gap) tick();
  endtask

  task automatic put(input logic [7:0] b);
    mdl_byte(b);
    send_raw(b);
  endtask

  task automatic put_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    put(SYNC);
    put(a);
    put(d);
    put(c);
  endtask

  task automatic long_idle();
    idle(TMO + 40);
    if (fbuf.size() > 0) begin
      exp_tmo++;
      fbuf.delete();
    end
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, wq.size(), ewq.size());
    while ((wq.size() > 0) && (ewq.size() > 0)) check({tag, "_wr"}, wq.pop_front(), ewq.pop_front());
    wq.delete();
    ewq.delete();
  endtask

  task automatic check_errs(input string tag);
    check({tag, "_ferr"}, n_ferr, exp_ferr);
    check({tag, "_tmo"}, n_tmo, exp_tmo);
    check({tag, "_ovr"}, n_ovr, exp_ovr);
    check({tag, "_cnt"}, frame_cnt, exp_cnt);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_addr"}, wr_addr, 0);
    check({tag, "_data"}, wr_data, 0);
    check({tag, "_cnt"}, frame_cnt, 0);
    check({tag, "_errs"}, {frame_err, timeout_err, overrun_err}, 0);
  endtask

  initial begin
    logic [7:0] a, d, c, c0;
    int         k, lf, w0;

    idle(3);
    check_zero("reset");
    rst = 1'b0;
    tick();

    // Basic frame with the sink ready
    wr_ready = 1'b1;
    w0 = n_wr_cyc;
    put_frame(8'h03, 8'h5C, 8'h5F);
    lf = last_fall;
    idle(8);
    check("t1_latency", first_wr - lf, DLY + 1);
    check("t1_wr_cycles", n_wr_cyc - w0, 1);
    check_writes("t1");
    check_errs("t1");

    // Bad checksum, then ADDR out of range
    put_frame(8'h03, 8'h5C, 8'h00);
    idle(8);
    check("t2_busy", busy, 0);
    put_frame(8'h13, 8'h00, 8'h13);
    idle(8);
    check_writes("t2");
    check_errs("t2");

    // Inter-byte timeout, then recovery
    put(SYNC);
    put(8'h02);
    lf = last_fall;
    long_idle();
    check("t3_tmo_cycle", tmo_at - lf, TMO + DLY);
    check("t3_busy", busy, 0);
    put_frame(8'h0A, 8'h5A, 8'h50);
    idle(8);
    check_writes("t3");
    check_errs("t3");

    // Stalled write with an overrunning byte
    wr_ready = 1'b0;
    put_frame(8'h05, 8'h77, 8'h72);
    idle(10);
    check("t4_wr_en", wr_en, 1);
    check("t4_addr", wr_addr, 4'h5);
    check("t4_data", wr_data, 8'h77);
    send_raw(SYNC);
    exp_ovr++;
    idle(80);
    check("t4_wr_en_held", wr_en, 1);
    check("t4_stall_nwr", wq.size(), 0);
    wr_ready = 1'b1;
    idle(4);
    check_writes("t4");
    put(8'h01);
    put(8'h02);
    put(8'h03);
    idle(8);
    check_writes("t4_after");
    check_errs("t4");

    // Noise before SYNC, then counter wrap
    put(8'h55);
    put(8'h11);
    put(SYNC);
    put(8'h01);
    put(8'h02);
    put(8'h03);
    idle(8);
    check_writes("t5");
    c0 = frame_cnt;
    for (int i = 0; i < 256; i++) begin
      a = 8'($urandom_range(0, 15));
      d = 8'($urandom_range(0, 255));
      put_frame(a, d, a ^ d);
    end
    idle(8);
    check("t5_wrap", frame_cnt, c0);
    check_writes("t5_loop");
    check_errs("t5");

    // Randomized byte streams: noise, truncated frames, bad ranges and bad checksums
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 9);
      if (k < 2) begin
        put(8'($urandom_range(0, 255)));
      end else if (k < 3) begin
        put(SYNC);
        put(8'($urandom_range(0, 255)));
        if ($urandom_range(0, 1) == 1) put(8'($urandom_range(0, 255)));
        long_idle();
      end else begin
        a = (k == 3) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
        d = 8'($urandom_range(0, 255));
        c = a ^ d;
        if (k == 4) c = c ^ 8'(1 << $urandom_range(0, 7));
        put_frame(a, d, c);
      end
    end
    long_idle();
    idle(8);
    check_writes("rnd");
    check_errs("rnd");

    // Reset in the middle of the DATA byte
    put(SYNC);
    put(8'h07);
    rx_int = 1'b1;
    idle(2);
    check("t6_busy_pre", busy, 1);
    #2 rst = 1'b1;
    #1 check_zero("t6_rst_data");
    rx_int = 1'b0;
    fbuf.delete();
    exp_cnt = 8'd0;
    idle(2);
    rst = 1'b0;
    tick();

    // Reset while a write is pending
    wr_ready = 1'b0;
    put_frame(8'h09, 8'h31, 8'h38);
    idle(5);
    check("t6_wr_pending", wr_en, 1);
    #2 rst = 1'b1;
    #1 check_zero("t6_rst_write");
    ewq.delete();
    fbuf.delete();
    exp_cnt = 8'd0;
    tick();
    rst = 1'b0;
    wr_ready = 1'b1;
    tick();
    put_frame(8'h0C, 8'h44, 8'h48);
    idle(8);
    check_writes("t6");
    check_errs("t6");

    check("err_exclusive", excl_viol, 0);
    check("wr_hold", hold_viol, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
